// File: rtl/text_arb_pkg.sv
// Shared encodings and default sizes for the text RAM arbiter.
// Optional hardware clear is built only when TEXTARB_CLEAR_EN is defined.
package text_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 2400;

    typedef enum logic [1:0] {
        CPU_IDLE   = 2'd0,
        CPU_ISSUED = 2'd1,
        CPU_DONE   = 2'd2
    } cpu_state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_VID  = 2'd1,
        SRC_CPU  = 2'd2,
        SRC_CLR  = 2'd3
    } src_t;

endpackage

// File: rtl/text_clear_seq.sv
// Clear-screen sweep: walks 0..DEPTH-1, advancing on every granted slot.
// Only instantiated when TEXTARB_CLEAR_EN is defined.
module text_clear_seq
    import text_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              grant,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic              busy
);

    // Busy flag and sweep pointer; start is ignored while sweeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            addr <= '0;
        end else if (!busy) begin
            if (start) begin
                busy <= 1'b1;
                addr <= '0;
            end
        end else if (grant) begin
            if (addr == ADDR_W'(DEPTH - 1))
                busy <= 1'b0;
            else
                addr <= addr + 1'b1;
        end
    end

    assign req = busy;

endmodule

// File: rtl/text_mem_arbiter.sv
// Single-port text RAM arbiter: video > CPU > clear, tagged read return.
// Define TEXTARB_CLEAR_EN to build the hardware clear-screen sequencer.
module text_mem_arbiter
    import text_arb_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                DEPTH     = DEPTH_DEF,
    parameter logic [DATA_W-1:0] FILL_CHAR = DATA_W'(8'h20)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    cpu_state_t        state_q, state_d;
    src_t              tag_d, tag_q;
    logic              vid_p1;
    logic              vid_in, cpu_in;
    logic              vid_grant, cpu_grant, clr_grant;
    logic              clr_req;
    logic [ADDR_W-1:0] clr_addr;

    assign vid_in    = vid_addr < ADDR_W'(DEPTH);
    assign cpu_in    = cpu_addr < ADDR_W'(DEPTH);
    assign vid_grant = vid_req & ~reset;
    assign cpu_grant = (state_q == CPU_IDLE) & cpu_req
                     & ~vid_req & ~reset;
    assign clr_grant = clr_req & ~vid_req & ~cpu_grant & ~reset;

`ifdef TEXTARB_CLEAR_EN
    text_clear_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear (
        .clk    (clk),
        .reset  (reset),
        .start  (clr_start),
        .grant  (clr_grant),
        .req    (clr_req),
        .addr   (clr_addr),
        .busy   (clr_busy)
    );
`else
    logic unused_clr_start;
    assign unused_clr_start = clr_start;
    assign clr_req  = 1'b0;
    assign clr_addr = '0;
    assign clr_busy = 1'b0;
`endif

    // Port mux: the single granted master drives the RAM and sets the tag.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        tag_d     = SRC_NONE;
        unique case (1'b1)
            vid_grant: begin
                mem_en   = vid_in;
                mem_addr = vid_addr;
                tag_d    = vid_in ? SRC_VID : SRC_NONE;
            end
            cpu_grant: begin
                mem_en    = cpu_in;
                mem_we    = cpu_we & cpu_in;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                tag_d     = cpu_in ? SRC_CPU : SRC_NONE;
            end
            clr_grant: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = clr_addr;
                mem_wdata = FILL_CHAR;
                tag_d     = SRC_CLR;
            end
            default: ;
        endcase
    end

    // Tag stage aligned with the RAM's one-cycle read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_q  <= SRC_NONE;
            vid_p1 <= 1'b0;
        end else begin
            tag_q  <= tag_d;
            vid_p1 <= vid_grant;
        end
    end

    // Video return stage; untagged slots yield zero data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_valid <= 1'b0;
            vid_data  <= '0;
        end else begin
            vid_valid <= vid_p1;
            vid_data  <= (tag_q == SRC_VID) ? mem_rdata : '0;
        end
    end

    // CPU FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= CPU_IDLE;
        else       state_q <= state_d;
    end

    // CPU read capture while the access returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cpu_rdata <= '0;
        else if (state_q == CPU_ISSUED)
            cpu_rdata <= (tag_q == SRC_CPU) ? mem_rdata : '0;
    end

    // CPU FSM next state and ready pulse.
    always_comb begin
        state_d   = state_q;
        cpu_ready = 1'b0;
        unique case (state_q)
            CPU_IDLE:   if (cpu_grant) state_d = CPU_ISSUED;
            CPU_ISSUED: state_d = CPU_DONE;
            CPU_DONE: begin
                cpu_ready = 1'b1;
                state_d   = CPU_IDLE;
            end
            default:    state_d = CPU_IDLE;
        endcase
    end

endmodule

// File: tb/tb_text_mem_arbiter.sv
// Directed bench for text_mem_arbiter with a video scoreboard.
// Clear tests are built when TEXTARB_CLEAR_EN is defined.
module tb_text_mem_arbiter;

    localparam int DEPTH = 2400;

    logic        clk = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [11:0] vid_addr;
    logic [7:0]  vid_data;
    logic        vid_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic        clr_start;
    logic        clr_busy;
    logic        mem_en;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    always #5 clk = ~clk;

    text_mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .vid_valid (vid_valid),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    logic [7:0] ram   [0:4095];
    logic [7:0] model [0:4095];

    // RAM environment: synchronous read, one-cycle latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        int         due;
    } vexp_t;

    vexp_t vq[$];
    vexp_t e_m;

    int checks = 0;
    int fails  = 0;
    int vpops  = 0;
    int we_viol = 0;
    int oor_en = 0;
    int mem_writes = 0;
    int last_we_cyc = -1;
    int req_cyc = 0;
    bit cpu_active = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard push: expected video data when a request is sampled.
    always @(posedge clk) begin
        if (!reset && vid_req)
            vq.push_back('{(vid_addr < DEPTH) ? model[vid_addr] : 8'h00,
                           cyc + 2});
    end

    // Monitor: pop video results, watch port usage and CPU pulses.
    always @(negedge clk) begin
        if (mem_en && mem_we) begin
            mem_writes++;
            last_we_cyc = cyc;
            if (vid_req) we_viol++;
        end
        if (mem_en && mem_addr >= DEPTH) oor_en++;
        if (vid_valid) begin
            if (vq.size() == 0) begin
                chk("vid_unexpected", vid_valid, 0);
            end else begin
                e_m = vq.pop_front();
                vpops++;
                chk("vid_data", vid_data, e_m.d);
                chk("vid_latency", cyc, e_m.due);
            end
        end else if (vq.size() != 0 && vq[0].due <= cyc) begin
            chk("vid_missing", vid_valid, 1);
            void'(vq.pop_front());
        end
        if (cpu_ready && !cpu_active)
            chk("cpu_unexpected", cpu_ready, cpu_active);
    end

    task automatic cpu_op(input bit we, input logic [11:0] a,
                          input logic [7:0] wd, input logic [7:0] exp_rd,
                          input bit chk_rd, input int exp_lat,
                          input string tag);
        int n;
        @(posedge clk); #1;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = wd;
        cpu_active = 1'b1;
        req_cyc = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ready && n < 200);
        chk({tag, "_ready"}, cpu_ready, 1);
        chk({tag, "_latency"}, cyc - req_cyc, exp_lat);
        if (chk_rd) chk({tag, "_rdata"}, cpu_rdata, exp_rd);
        if (we && a < DEPTH) model[a] = wd;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        cpu_active = 1'b0;
    endtask

    initial begin
        int base;
        int w0;
        int n;
        reset = 1'b1;
        vid_req = 1'b1;
        vid_addr = 12'd5;
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 12'd5;
        cpu_wdata = 8'h00;
        clr_start = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            ram[i] = 8'(i) ^ 8'h5A;
            model[i] = 8'(i) ^ 8'h5A;
        end
        ram[5] = 8'h41;
        model[5] = 8'h41;

        // Reset held with both requesters active.
        repeat (3) @(negedge clk);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_vid_valid", vid_valid, 0);
        chk("rst_vid_data", vid_data, 0);
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_clr_busy", clr_busy, 0);
        reset = 1'b0;
        cpu_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 vid_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("t1_vid_count", vpops, 3);

        // CPU read with video idle.
        cpu_op(1'b0, 12'd5, 8'h00, 8'h41, 1'b1, 2, "t2");

        // CPU write stalled by a 10-cycle video burst.
        base = vpops;
        fork
            begin
                @(posedge clk); #1;
                for (int i = 0; i < 10; i++) begin
                    vid_req = 1'b1;
                    vid_addr = 12'(200 + i);
                    @(posedge clk); #1;
                end
                vid_req = 1'b0;
            end
            cpu_op(1'b1, 12'd100, 8'h7E, 8'h00, 1'b0, 12, "t3w");
        join
        chk("t3_we_cycle", last_we_cyc, req_cyc + 10);
        repeat (3) @(negedge clk);
        chk("t3_vid_count", vpops - base, 10);
        cpu_op(1'b0, 12'd100, 8'h00, 8'h7E, 1'b1, 2, "t3r");

        // Out-of-range CPU and video accesses.
        w0 = mem_writes;
        cpu_op(1'b1, 12'd2400, 8'hC3, 8'h00, 1'b0, 2, "t4w");
        chk("t4_no_write", mem_writes, w0);
        cpu_op(1'b0, 12'd2400, 8'h00, 8'h00, 1'b1, 2, "t4r");
        @(posedge clk); #1;
        vid_req = 1'b1;
        vid_addr = 12'd2400;
        @(posedge clk); #1;
        vid_addr = 12'hFFF;
        @(posedge clk); #1;
        vid_addr = 12'd2399;
        @(posedge clk); #1;
        vid_req = 1'b0;
        repeat (4) @(negedge clk);

`ifdef TEXTARB_CLEAR_EN
        // Full clear with a second start ignored mid-sweep.
        @(negedge clk);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        n = 0;
        while (n < 3000) begin
            if (!clr_busy) break;
            n++;
            clr_start = (n == 1000);
            @(negedge clk);
        end
        clr_start = 1'b0;
        chk("t5_busy_cycles", n, 2400);
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h20;
        base = vpops;
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) begin
            vid_req = 1'b1;
            vid_addr = 12'(i);
            @(posedge clk); #1;
        end
        vid_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_sweep_count", vpops - base, DEPTH);

        // Reset in the middle of a clear.
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        n = 0;
        while (n < 3000 && !(mem_en && mem_we && mem_addr == 12'd1000)) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reached_1000", mem_addr, 1000);
        reset = 1'b1;
        #1 chk("t6_busy_in_reset", clr_busy, 0);
        @(negedge clk);
        reset = 1'b0;
        w0 = mem_writes;
        repeat (10) @(negedge clk);
        chk("t6_busy_after", clr_busy, 0);
        chk("t6_no_resume", mem_writes, w0);
`endif

        repeat (5) @(negedge clk);
        chk("we_during_vid", we_viol, 0);
        chk("oor_enable", oor_en, 0);
        chk("vid_queue_empty", vq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
